mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single core memory port between instruction fetch (imem) and load/store (dmem,
//  address/byteenable from the address-generation stage). Buffers one request per requester,
//  arbitrates (dmem priority with anti-starvation cap), holds the bus request until accepted
//  and routes the response back. Sits between fetch/LSU and the external memory/bus.
// PARAMETERS
//  MAX_DBURST  4   consecutive dmem grants allowed while imem is pending before imem is forced (>=1)
// PORTS
//  reset        in   1   synchronous, active-low reset
//  clock        in   1   single clock, rising edge
//  imem_valid   in   1   fetch request (1-cycle pulse sufficient)
//  imem_addr    in   32  fetch address (word aligned)
//  imem_ready   out  1   fetch response valid (1-cycle pulse)
//  imem_rdata   out  32  fetch data
//  dmem_valid   in   1   load/store request (1-cycle pulse sufficient)
//  dmem_addr    in   32  data address
//  dmem_wdata   in   32  store data
//  dmem_wstrb   in   4   byte enables for store; 0 = load
//  dmem_ready   out  1   data response valid (1-cycle pulse)
//  dmem_rdata   out  32  load data (don't-care for stores)
//  mem_valid    out  1   bus request, held until mem_ready
//  mem_instr    out  1   1 = current bus request is a fetch
//  mem_addr     out  32  bus address, stable while mem_valid
//  mem_wdata    out  32  bus write data
//  mem_wstrb    out  4   bus byte strobes (0 = read)
//  mem_ready    in   1   bus accept + response this cycle
//  mem_rdata    in   32  bus read data, valid with mem_ready
// BEHAVIOUR
//  - Reset (reset==0 at edge): state IDLE, both pending slots empty, dcnt=0; all outputs 0.
//    Reset mid-transaction aborts it: no response delivered; a later stray mem_ready in IDLE ignored.
//  - Capture: *_valid loads that requester's slot (addr/wdata/wstrb). Requester must not
//    re-request before its *_ready; violation = simulation assertion, new request dropped.
//  - States: IDLE, BUSY_I, BUSY_D. In IDLE candidates = slot_pending | incoming valid.
//    Grant: dmem if candidate, unless imem candidate and dcnt==MAX_DBURST -> imem. Else imem.
//    Granted slot is driven on mem_* from next cycle; state -> BUSY_I/BUSY_D.
//  - dcnt: +1 on dmem grant while imem candidate (saturates at MAX_DBURST); cleared on imem grant
//    or dmem grant with no imem candidate.
//  - BUSY: mem_valid=1, mem_* registered and stable. mem_ready (may arrive first BUSY cycle)
//    -> next cycle: matching *_ready=1, *_rdata=mem_rdata (registered), slot cleared, state IDLE,
//    mem_valid=0. One-cycle bus bubble between transactions; no outstanding pipelining.
//  - Latency: request in cycle 0 to idle arbiter -> mem_valid cycle 1; mem_ready cycle k -> *_ready k+1.
//  - Simultaneous: both valids in IDLE -> dmem first, imem stays pending. New valid in cycle of
//    mem_ready is captured and arbitrated in the following IDLE cycle.
//  - *_ready and *_rdata hold 0 when not responding.
// STRUCTURE
//  - Package (wires): mem_arb_state enum {IDLE,BUSY_I,BUSY_D}; mem_req_type {valid,addr,wdata,wstrb}.
//  - Package (constants): default MAX_DBURST.
//  - Sub-module mem_req_buffer: one pending slot (capture, hold, clear); instantiated for imem and dmem.
//  - Top: arbiter FSM, dcnt counter, bus output registers, response routing.
// TESTING
//  - Reset: hold reset=0 3 cycles with valids toggling -> all outputs 0, no mem_valid after release.
//  - Single fetch: imem_valid, addr 0x100, mem_ready 2 cycles later with rdata 0x00000013
//    -> mem_valid cycle1 mem_instr=1 addr 0x100; imem_ready+rdata 0x13 on cycle after mem_ready.
//  - Collision: imem 0x200 and dmem store 0x8000 wdata 0xDEADBEEF wstrb 0xF same cycle
//    -> store issued first (wstrb 0xF, mem_instr=0), then fetch 0x200; one dmem_ready, one imem_ready.
//  - Starvation: imem pending, dmem re-requests every response, MAX_DBURST=4 -> exactly 4 dmem
//    bus transactions, then fetch granted, then dcnt=0.
//  - Zero-wait memory: mem_ready tied 1 -> each transaction 1 BUSY cycle, response next cycle, data intact.
//  - Reset mid-BUSY_D: reset=0 while mem_valid=1 -> no dmem_ready; subsequent mem_ready ignored.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and defaults for the fetch/load-store memory arbiter
package mem_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} mem_arb_state;
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_type;
    localparam int MAX_DBURST_DEF = 4;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, load/store and memory bus signals; slave = arbiter view, master = environment view
interface mem_arbiter_if;
    logic        imem_valid;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        dmem_valid;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    modport slave (
        input  imem_valid, imem_addr, dmem_valid, dmem_addr, dmem_wdata, dmem_wstrb, mem_ready, mem_rdata,
        output imem_ready, imem_rdata, dmem_ready, dmem_rdata, mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb
    );
    modport master (
        output imem_valid, imem_addr, dmem_valid, dmem_addr, dmem_wdata, dmem_wstrb, mem_ready, mem_rdata,
        input  imem_ready, imem_rdata, dmem_ready, dmem_rdata, mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/mem_req_buffer.sv
// mem_req_buffer: one pending request slot; cand is the held request, or the incoming one when empty
//   clock, reset (sync, active low); in_*: incoming request; clear: drop slot after its response; cand: arbitration view
module mem_req_buffer
    import mem_arbiter_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [3:0]  in_wstrb,
    input  logic        clear,
    output mem_req_type cand
);
    mem_req_type slot;
    always_ff @(posedge clock) begin
        if (!reset) slot <= '0;
        else if (clear) slot <= '0;
        else if (in_valid && !slot.valid) slot <= {1'b1, in_addr, in_wdata, in_wstrb};
    end
    assign cand = slot.valid ? slot : {in_valid, in_addr, in_wdata, in_wstrb};
    assert property (@(posedge clock) reset && in_valid |-> !slot.valid)
        else $error("mem_req_buffer: new request while one is pending, dropped");
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and load/store, dmem priority with a starvation cap
//   clock, reset (sync, active low); bus.imem_*/bus.dmem_*: requester side; bus.mem_*: memory side
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_DBURST = MAX_DBURST_DEF
) (
    input logic          clock,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    localparam int CW = $clog2(MAX_DBURST + 1);
    localparam logic [CW-1:0] DMAX = CW'(MAX_DBURST);
    mem_arb_state  state;
    logic [CW-1:0] dcnt;
    mem_req_type   i_req, d_req;
    logic          grant_d, i_done, d_done;
    assign i_done  = state == BUSY_I && bus.mem_ready;
    assign d_done  = state == BUSY_D && bus.mem_ready;
    // dcnt counts dmem grants taken while fetch was waiting; at the cap fetch wins
    assign grant_d = d_req.valid && !(i_req.valid && dcnt == DMAX);
    mem_req_buffer u_ibuf (
        .clock(clock), .reset(reset), .in_valid(bus.imem_valid), .in_addr(bus.imem_addr),
        .in_wdata(32'h0), .in_wstrb(4'h0), .clear(i_done), .cand(i_req)
    );
    mem_req_buffer u_dbuf (
        .clock(clock), .reset(reset), .in_valid(bus.dmem_valid), .in_addr(bus.dmem_addr),
        .in_wdata(bus.dmem_wdata), .in_wstrb(bus.dmem_wstrb), .clear(d_done), .cand(d_req)
    );
    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= IDLE;
            dcnt           <= '0;
            bus.mem_valid  <= 1'b0;
            bus.mem_instr  <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.mem_wstrb  <= '0;
            bus.imem_ready <= 1'b0;
            bus.imem_rdata <= '0;
            bus.dmem_ready <= 1'b0;
            bus.dmem_rdata <= '0;
        end else begin
            bus.imem_ready <= i_done;
            bus.imem_rdata <= i_done ? bus.mem_rdata : '0;
            bus.dmem_ready <= d_done;
            bus.dmem_rdata <= d_done ? bus.mem_rdata : '0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state         <= BUSY_D;
                        dcnt          <= i_req.valid ? (dcnt == DMAX ? dcnt : dcnt + 1'b1) : '0;
                        bus.mem_valid <= 1'b1;
                        bus.mem_instr <= 1'b0;
                        bus.mem_addr  <= d_req.addr;
                        bus.mem_wdata <= d_req.wdata;
                        bus.mem_wstrb <= d_req.wstrb;
                    end else if (i_req.valid) begin
                        state         <= BUSY_I;
                        dcnt          <= '0;
                        bus.mem_valid <= 1'b1;
                        bus.mem_instr <= 1'b1;
                        bus.mem_addr  <= i_req.addr;
                        bus.mem_wdata <= i_req.wdata;
                        bus.mem_wstrb <= i_req.wstrb;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (bus.mem_ready) begin
                        state         <= IDLE;
                        bus.mem_valid <= 1'b0;
                        bus.mem_instr <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
    localparam int MAXB = 4;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    mem_arbiter_if bus();
    mem_arbiter #(.MAX_DBURST(MAXB)) dut (.clock(clock), .reset(reset), .bus(bus.slave));
    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.imem_valid = 1'b0; bus.dmem_valid = 1'b0; bus.mem_ready = 1'b0; bus.mem_rdata = '0;
        bus.imem_addr = '0; bus.dmem_addr = '0; bus.dmem_wdata = '0; bus.dmem_wstrb = '0;
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            reset = 1'b0;
            bus.imem_valid = (c % 2 == 0); bus.dmem_valid = (c % 2 == 1); bus.mem_ready = (c % 2 == 1);
            bus.imem_addr = $urandom; bus.dmem_addr = $urandom; bus.dmem_wdata = $urandom;
            bus.dmem_wstrb = 4'hF; bus.mem_rdata = $urandom;
            cyc();
            checks++;
            if ({bus.mem_valid, bus.mem_instr, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.imem_ready,
                 bus.imem_rdata, bus.dmem_ready, bus.dmem_rdata} !== 136'h0) begin
                errors++; $display("FAIL reset_outputs cycle %0d got mem_valid=%b addr=%h imem_ready=%b dmem_ready=%b want all 0",
                                   c, bus.mem_valid, bus.mem_addr, bus.imem_ready, bus.dmem_ready);
            end
        end
        reset = 1'b1; bus.imem_valid = 1'b0; bus.dmem_valid = 1'b0; bus.mem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cyc();
            checks++;
            if ({bus.mem_valid, bus.imem_ready, bus.dmem_ready} !== 3'b000) begin
                errors++; $display("FAIL reset_release cycle %0d got valid/iready/dready=%b want 000",
                                   c, {bus.mem_valid, bus.imem_ready, bus.dmem_ready});
            end
        end
    endtask

    task automatic test_single_fetch();
        do_reset();
        bus.imem_valid = 1'b1; bus.imem_addr = 32'h100;
        cyc();
        bus.imem_valid = 1'b0;
        checks++;
        if ({bus.mem_valid, bus.mem_instr, bus.mem_addr, bus.mem_wstrb} !== {1'b1, 1'b1, 32'h100, 4'h0}) begin
            errors++; $display("FAIL fetch_issue got valid=%b instr=%b addr=%h wstrb=%h want 1 1 00000100 0",
                               bus.mem_valid, bus.mem_instr, bus.mem_addr, bus.mem_wstrb);
        end
        cyc();
        checks++;
        if ({bus.mem_valid, bus.mem_addr, bus.imem_ready} !== {1'b1, 32'h100, 1'b0}) begin
            errors++; $display("FAIL fetch_hold got valid=%b addr=%h iready=%b want 1 00000100 0",
                               bus.mem_valid, bus.mem_addr, bus.imem_ready);
        end
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h13;
        cyc();
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;
        checks++;
        if ({bus.imem_ready, bus.imem_rdata, bus.dmem_ready, bus.mem_valid} !== {1'b1, 32'h13, 1'b0, 1'b0}) begin
            errors++; $display("FAIL fetch_resp got iready=%b rdata=%h dready=%b valid=%b want 1 00000013 0 0",
                               bus.imem_ready, bus.imem_rdata, bus.dmem_ready, bus.mem_valid);
        end
        cyc();
        checks++;
        if ({bus.imem_ready, bus.imem_rdata} !== 33'h0) begin
            errors++; $display("FAIL fetch_resp_clear got iready=%b rdata=%h want 0 0", bus.imem_ready, bus.imem_rdata);
        end
    endtask

    task automatic test_collision();
        do_reset();
        bus.imem_valid = 1'b1; bus.imem_addr = 32'h200;
        bus.dmem_valid = 1'b1; bus.dmem_addr = 32'h8000; bus.dmem_wdata = 32'hDEADBEEF; bus.dmem_wstrb = 4'hF;
        cyc();
        bus.imem_valid = 1'b0; bus.dmem_valid = 1'b0;
        checks++;
        if ({bus.mem_valid, bus.mem_instr, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !==
            {1'b1, 1'b0, 32'h8000, 32'hDEADBEEF, 4'hF}) begin
            errors++; $display("FAIL collision_store got valid=%b instr=%b addr=%h wdata=%h wstrb=%h want 1 0 00008000 deadbeef f",
                               bus.mem_valid, bus.mem_instr, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
        end
        bus.mem_ready = 1'b1;
        cyc();
        bus.mem_ready = 1'b0;
        checks++;
        if ({bus.dmem_ready, bus.imem_ready, bus.mem_valid} !== 3'b100) begin
            errors++; $display("FAIL collision_store_resp got dready/iready/valid=%b want 100",
                               {bus.dmem_ready, bus.imem_ready, bus.mem_valid});
        end
        cyc();
        checks++;
        if ({bus.mem_valid, bus.mem_instr, bus.mem_addr, bus.mem_wstrb} !== {1'b1, 1'b1, 32'h200, 4'h0}) begin
            errors++; $display("FAIL collision_fetch got valid=%b instr=%b addr=%h wstrb=%h want 1 1 00000200 0",
                               bus.mem_valid, bus.mem_instr, bus.mem_addr, bus.mem_wstrb);
        end
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hCAFE0001;
        cyc();
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;
        checks++;
        if ({bus.imem_ready, bus.imem_rdata, bus.dmem_ready} !== {1'b1, 32'hCAFE0001, 1'b0}) begin
            errors++; $display("FAIL collision_fetch_resp got iready=%b rdata=%h dready=%b want 1 cafe0001 0",
                               bus.imem_ready, bus.imem_rdata, bus.dmem_ready);
        end
        cyc();
        checks++;
        if ({bus.imem_ready, bus.dmem_ready, bus.mem_valid} !== 3'b000) begin
            errors++; $display("FAIL collision_done got iready/dready/valid=%b want 000",
                               {bus.imem_ready, bus.dmem_ready, bus.mem_valid});
        end
    endtask

    task automatic test_starvation();
        int g = 0;
        logic pmv = 1'b0;
        do_reset();
        bus.imem_valid = 1'b1; bus.imem_addr = 32'h300;
        bus.dmem_valid = 1'b1; bus.dmem_addr = 32'h9000; bus.dmem_wstrb = 4'h0;
        for (int c = 0; c < 200 && g < 10; c++) begin
            cyc();
            bus.imem_valid = 1'b0; bus.dmem_valid = 1'b0;
            if (bus.mem_valid && !pmv) begin
                checks++;
                if (bus.mem_instr !== (g % 5 == 4)) begin
                    errors++; $display("FAIL starve_order grant %0d got instr=%b want %b", g, bus.mem_instr, g % 5 == 4);
                end
                g++;
            end
            if (bus.imem_ready) begin bus.imem_valid = 1'b1; bus.imem_addr = bus.imem_addr + 4; end
            if (bus.dmem_ready) begin bus.dmem_valid = 1'b1; bus.dmem_addr = bus.dmem_addr + 4; end
            pmv = bus.mem_valid;
            bus.mem_ready = bus.mem_valid;
        end
        bus.mem_ready = 1'b0; bus.imem_valid = 1'b0; bus.dmem_valid = 1'b0;
        checks++;
        if (g != 10) begin
            errors++; $display("FAIL starve_progress got %0d grants want 10", g);
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] a, d;
        logic is_i;
        do_reset();
        bus.mem_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            is_i = 1'($urandom_range(0, 1));
            a = $urandom & 32'hFFFC;
            d = a ^ 32'h5A5A5A5A;
            bus.mem_rdata = '0;
            if (is_i) begin bus.imem_valid = 1'b1; bus.imem_addr = a; end
            else begin bus.dmem_valid = 1'b1; bus.dmem_addr = a; bus.dmem_wstrb = 4'h0; end
            cyc();
            bus.imem_valid = 1'b0; bus.dmem_valid = 1'b0;
            checks++;
            if ({bus.mem_valid, bus.mem_instr, bus.mem_addr, bus.imem_ready, bus.dmem_ready} !==
                {1'b1, is_i, a, 2'b00}) begin
                errors++; $display("FAIL zw_issue %0d got valid=%b instr=%b addr=%h readies=%b want 1 %b %h 00",
                                   n, bus.mem_valid, bus.mem_instr, bus.mem_addr, {bus.imem_ready, bus.dmem_ready}, is_i, a);
            end
            bus.mem_rdata = d;
            cyc();
            checks++;
            if ({bus.mem_valid, bus.imem_ready, bus.imem_rdata, bus.dmem_ready, bus.dmem_rdata} !==
                {1'b0, is_i, is_i ? d : 32'h0, !is_i, is_i ? 32'h0 : d}) begin
                errors++; $display("FAIL zw_resp %0d got valid=%b iready=%b irdata=%h dready=%b drdata=%h want instr=%b data=%h",
                                   n, bus.mem_valid, bus.imem_ready, bus.imem_rdata, bus.dmem_ready, bus.dmem_rdata, is_i, d);
            end
        end
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        bus.dmem_valid = 1'b1; bus.dmem_addr = 32'hA000; bus.dmem_wdata = 32'h12345678; bus.dmem_wstrb = 4'h3;
        cyc();
        bus.dmem_valid = 1'b0;
        checks++;
        if ({bus.mem_valid, bus.mem_instr, bus.mem_wstrb} !== {1'b1, 1'b0, 4'h3}) begin
            errors++; $display("FAIL midrst_issue got valid=%b instr=%b wstrb=%h want 1 0 3",
                               bus.mem_valid, bus.mem_instr, bus.mem_wstrb);
        end
        cyc();
        reset = 1'b0;
        cyc();
        checks++;
        if ({bus.mem_valid, bus.dmem_ready} !== 2'b00) begin
            errors++; $display("FAIL midrst_abort got valid/dready=%b want 00", {bus.mem_valid, bus.dmem_ready});
        end
        reset = 1'b1; bus.mem_ready = 1'b1; bus.mem_rdata = 32'hBAD0BAD0;
        for (int c = 0; c < 3; c++) begin
            cyc();
            checks++;
            if ({bus.mem_valid, bus.imem_ready, bus.dmem_ready, bus.dmem_rdata} !== 35'h0) begin
                errors++; $display("FAIL midrst_stray cycle %0d got valid=%b iready=%b dready=%b drdata=%h want 0",
                                   c, bus.mem_valid, bus.imem_ready, bus.dmem_ready, bus.dmem_rdata);
            end
        end
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    endtask

    // Model: each requester has an outstanding flag and a waiting-for-grant flag; the bus is idle for
    // one cycle after each response and grants follow the priority/cap rule on the waiting set.
    task automatic test_random();
        logic iw = 0, dw = 0, io = 0, dout = 0, mv = 0, rdy = 0, any = 0, ci = 0, er_i = 0, er_d = 0, nmv, ei;
        logic [31:0] ia = 0, da = 0, dwd = 0, ca = 0, cwd = 0, ed = 0;
        logic [3:0] dws = 0, cws = 0;
        int burst = 0, ni = 0, nd = 0;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            cyc();
            nmv = mv ? !rdy : any;
            if (nmv && !mv) begin
                ei = !(dw && !(iw && burst == MAXB));
                ci = ei; ca = ei ? ia : da; cwd = ei ? 32'h0 : dwd; cws = ei ? 4'h0 : dws;
                if (ei) begin iw = 0; burst = 0; end
                else begin burst = iw ? burst + 1 : 0; dw = 0; end
            end
            mv = nmv;
            checks++;
            if (bus.mem_valid !== mv) begin
                errors++; $display("FAIL rnd_mem_valid cycle %0d got %b want %b", c, bus.mem_valid, mv);
            end
            if (mv) begin
                checks++;
                if ({bus.mem_instr, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== {ci, ca, cwd, cws}) begin
                    errors++; $display("FAIL rnd_bus cycle %0d got instr=%b addr=%h wdata=%h wstrb=%h want %b %h %h %h",
                                       c, bus.mem_instr, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, ci, ca, cwd, cws);
                end
            end
            checks++;
            if ({bus.imem_ready, bus.imem_rdata} !== {er_i, er_i ? ed : 32'h0}) begin
                errors++; $display("FAIL rnd_imem_resp cycle %0d got %b %h want %b %h", c, bus.imem_ready, bus.imem_rdata, er_i, ed);
            end
            checks++;
            if ({bus.dmem_ready, bus.dmem_rdata} !== {er_d, er_d ? ed : 32'h0}) begin
                errors++; $display("FAIL rnd_dmem_resp cycle %0d got %b %h want %b %h", c, bus.dmem_ready, bus.dmem_rdata, er_d, ed);
            end
            if (er_i) begin io = 0; ni++; end
            if (er_d) begin dout = 0; nd++; end
            rdy = mv && $urandom_range(0, 2) == 0;
            ed = rdy ? $urandom : 32'h0;
            bus.mem_ready = rdy; bus.mem_rdata = ed;
            er_i = rdy && ci; er_d = rdy && !ci;
            bus.imem_valid = 1'b0; bus.dmem_valid = 1'b0;
            if (!io && $urandom_range(0, 2) == 0) begin
                io = 1; iw = 1; ia = $urandom & 32'hFFFFFFFC;
                bus.imem_valid = 1'b1; bus.imem_addr = ia;
            end
            if (!dout && $urandom_range(0, 1) == 0) begin
                dout = 1; dw = 1; da = $urandom; dwd = $urandom;
                dws = $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'h0;
                bus.dmem_valid = 1'b1; bus.dmem_addr = da; bus.dmem_wdata = dwd; bus.dmem_wstrb = dws;
            end
            any = iw || dw;
        end
        bus.mem_ready = 1'b0; bus.imem_valid = 1'b0; bus.dmem_valid = 1'b0;
        checks++;
        if (ni == 0 || nd == 0) begin
            errors++; $display("FAIL rnd_progress got imem=%0d dmem=%0d responses want both nonzero", ni, nd);
        end
    endtask

    initial begin
        bus.imem_valid = 1'b0; bus.dmem_valid = 1'b0; bus.mem_ready = 1'b0; bus.mem_rdata = '0;
        bus.imem_addr = '0; bus.dmem_addr = '0; bus.dmem_wdata = '0; bus.dmem_wstrb = '0;
        test_reset();
        test_single_fetch();
        test_collision();
        test_starvation();
        test_zero_wait();
        test_reset_mid_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
